// File: rtl/usr_sequencer.sv
// -----------------------------------------------------------------------------
// usr_sequencer
//
// Command-driven controller for one 4-bit universal shift register
// (clear / hold / shift-right / shift-left / parallel-load). A host issues one
// command at a time over a valid/ready handshake. The sequencer then drives the
// register's clr/sel/serial/parallel inputs for as many cycles as the command
// needs. It streams every bit shifted out of the register. When the command
// finishes it raises a one-cycle done pulse, and the final register contents
// appear on result.
//
// Ports
//   clk                 rising-edge clock
//   clr                 asynchronous active-high reset; also clears the register
//   cmd_valid/cmd_ready command handshake (ready only while idle)
//   cmd_op              0 CLEAR, 1 LOAD, 2 SHR, 3 SHL, 4 ROR, 5 ROL, 6/7 NOP
//   cmd_count           number of shifts for shift/rotate commands
//   cmd_data            parallel word for LOAD
//   cmd_fill            serial fill bit for SHR/SHL
//   usr_out             current contents of the controlled register
//   usr_clr             register synchronous clear
//   usr_sel             register mode: 00 hold, 01 right, 10 left, 11 load
//   usr_right_input     bit entering the MSB on a right shift
//   usr_left_input      bit entering the LSB on a left shift
//   usr_parallel_input  load word (zero outside LOAD)
//   ser_out/ser_valid   bit leaving the register on this cycle's shift
//   done                one-cycle completion pulse
//   result              register contents captured at completion
// -----------------------------------------------------------------------------
module usr_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] usr_out,
    output logic             usr_clr,
    output logic [1:0]       usr_sel,
    output logic             usr_right_input,
    output logic             usr_left_input,
    output logic [WIDTH-1:0] usr_parallel_input,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [2:0] OP_CLEAR = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_ROL   = 3'd5;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic             fill_q;
    logic             rot_q;      // rotate: the serial input is fed from the bit that leaves
    logic             left_q;     // shift direction is toward the MSB
    logic [WIDTH-1:0] par_q;
    logic [1:0]       sel_q;
    logic             clear_q;
    logic             ser_valid_q;
    logic             done_q;
    logic             ready_q;
    logic [WIDTH-1:0] result_q;

    logic is_shift_op;
    logic is_left_op;
    logic is_rot_op;

    assign is_shift_op = (cmd_op == OP_SHR) || (cmd_op == OP_SHL) ||
                         (cmd_op == OP_ROR) || (cmd_op == OP_ROL);
    assign is_left_op  = (cmd_op == OP_SHL) || (cmd_op == OP_ROL);
    assign is_rot_op   = (cmd_op == OP_ROR) || (cmd_op == OP_ROL);

    // Holding reset keeps the register cleared on every edge, so the clear
    // is an OR with the async reset and not a purely registered term.
    assign usr_clr            = clr | clear_q;
    assign usr_sel            = sel_q;
    assign usr_parallel_input = par_q;
    assign ser_valid          = ser_valid_q;
    assign done               = done_q;
    assign result             = result_q;
    assign cmd_ready          = ready_q;

    // The serial inputs and the outgoing bit depend on the live register
    // value, so they are decoded combinationally from usr_out.
    // ser_valid_q is high exactly while shifting.
    assign usr_right_input = ser_valid_q & ~left_q & (rot_q ? usr_out[0] : fill_q);
    assign usr_left_input  = ser_valid_q &  left_q & (rot_q ? usr_out[WIDTH-1] : fill_q);
    assign ser_out         = ser_valid_q & (left_q ? usr_out[WIDTH-1] : usr_out[0]);

    // Each output register is loaded with its value for the destination
    // state, so all outputs change together with the state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= S_IDLE;
            remaining   <= '0;
            fill_q      <= 1'b0;
            rot_q       <= 1'b0;
            left_q      <= 1'b0;
            par_q       <= '0;
            sel_q       <= SEL_HOLD;
            clear_q     <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            result_q    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && ready_q) begin
                        ready_q   <= 1'b0;
                        remaining <= cmd_count;
                        fill_q    <= cmd_fill;
                        rot_q     <= is_rot_op;
                        left_q    <= is_left_op;
                        if (cmd_op == OP_CLEAR) begin
                            state   <= S_CLEAR;
                            clear_q <= 1'b1;
                        end else if (cmd_op == OP_LOAD) begin
                            state <= S_LOAD;
                            sel_q <= SEL_LOAD;
                            par_q <= cmd_data;
                        end else if (is_shift_op && (cmd_count != '0)) begin
                            state       <= S_SHIFT;
                            sel_q       <= is_left_op ? SEL_LEFT : SEL_RIGHT;
                            ser_valid_q <= 1'b1;
                        end else begin
                            // Zero-count shifts and NOPs complete without touching the register.
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    clear_q <= 1'b0;
                    state   <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_LOAD: begin
                    sel_q  <= SEL_HOLD;
                    par_q  <= '0;
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_SHIFT: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        sel_q       <= SEL_HOLD;
                        ser_valid_q <= 1'b0;
                        state       <= S_DONE;
                        done_q      <= 1'b1;
                    end
                end
                S_DONE: begin
                    // The register finished its final update on the edge
                    // that entered this state, so usr_out is the final value.
                    result_q <= usr_out;
                    done_q   <= 1'b0;
                    ready_q  <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state       <= S_IDLE;
                    sel_q       <= SEL_HOLD;
                    par_q       <= '0;
                    clear_q     <= 1'b0;
                    ser_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                    ready_q     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/usr_sequencer.md
Name: usr_sequencer

Overview:
- Command-driven controller for the 4-bit universal shift register (clear / hold / shift-right / shift-left / parallel-load datapath).
- Accepts one command at a time over a valid/ready port and drives the register's clr, sel, serial and parallel inputs for the required number of cycles.
- Streams each shifted-out bit and reports completion with the final register contents.
- Sits between a host/control FSM and one shift-register instance; it is that register's only driver.

Parameters:
- WIDTH, 4, width of the controlled shift register and of data/result buses.
- CNT_W, 3, width of the shift-count field; max shifts per command = 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- clr  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  0=CLEAR, 1=LOAD, 2=SHR, 3=SHL, 4=ROR, 5=ROL, 6/7=NOP.
- cmd_count  input  CNT_W  number of shifts (shift/rotate ops only).
- cmd_data  input  WIDTH  parallel word (LOAD only).
- cmd_fill  input  1  serial fill bit (SHR/SHL only).
- usr_out  input  WIDTH  current contents of the controlled register.
- usr_clr  output  1  to register clr (synchronous clear in the register).
- usr_sel  output  2  to register sel: 00 hold, 01 shift right, 10 shift left, 11 load.
- usr_right_input  output  1  bit entering MSB on sel=01.
- usr_left_input  output  1  bit entering LSB on sel=10.
- usr_parallel_input  output  WIDTH  load word.
- ser_out  output  1  bit leaving the register on this cycle's shift.
- ser_valid  output  1  ser_out valid.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  register contents at done; held until next done.

Behaviour:
- States: IDLE, CLEAR, LOAD, SHIFT, DONE. Async clr forces IDLE, all latched fields to 0, result=0, done=0, ser_valid=0.
- usr_clr = clr OR (state==CLEAR); the register is therefore cleared on every edge while reset is held.
- cmd_ready=1 only in IDLE. Handshake fires on an edge with cmd_valid & cmd_ready; op, count, data and fill are latched then. cmd_valid in other states is ignored and does not stall.
- IDLE transitions on accept:
  - CLEAR -> CLEAR.
  - LOAD -> LOAD.
  - Shift/rotate op with count>0 -> SHIFT, remaining=count.
  - Shift/rotate op with count=0 -> DONE.
  - NOP -> DONE.
- CLEAR: usr_clr=1, usr_sel=00, for one cycle -> DONE.
- LOAD: usr_sel=11, usr_parallel_input=latched data, for one cycle -> DONE. usr_parallel_input=0 in all other states.
- SHIFT: usr_sel=01 for SHR/ROR, 10 for SHL/ROL.
  - Serial inputs: SHR right_input=fill; ROR right_input=usr_out[0]; SHL left_input=fill; ROL left_input=usr_out[WIDTH-1]. The unused serial input is 0.
  - ser_valid=1; ser_out=usr_out[0] (right) or usr_out[WIDTH-1] (left).
  - remaining decrements each edge; when remaining==1 go to DONE.
- DONE: usr_sel=00, done=1, result<=usr_out captured at the end of this cycle (register has completed its last update) -> IDLE.
- IDLE: usr_sel=00, usr_clr=0 (outside reset), ser_valid=0.
- Latency: accept at edge E, N shifts occupy cycles E..E+N-1, done high in cycle E+N, cmd_ready high again in cycle E+N+1. CLEAR/LOAD: done in cycle E+1. count=0/NOP: done in cycle E, register untouched.
- Back-to-back: min command spacing is N+2 cycles for shifts and 3 cycles for CLEAR/LOAD.
- Reset mid-command abandons the command with no done; register contents are cleared via usr_clr.
- All state updates on rising clk; clr is the only asynchronous term.

Test Plan:
- Reset then LOAD data=1011 -> usr_sel=11 for 1 cycle; done next cycle with result=1011; ready returns.
- After load 1011, SHR count=2 fill=1 -> ser_out 1,1 with ser_valid 2 cycles; result=1110.
- After load 1001, ROL count=4 -> ser_out 1,0,0,1; result=1001 (full rotation); usr_left_input tracks usr_out[3].
- SHL count=0 and op=7 -> done in the cycle after accept, usr_sel stays 00, result unchanged.
- Assert clr during SHIFT (count=7, after 3 shifts) -> immediate IDLE; cmd_ready=1 after release; no done; usr_out=0000 after next edge.
- Hold cmd_valid high continuously with alternating LOAD/CLEAR commands -> one accept per 3 cycles; no command is accepted while busy; results alternate data/0000.
